// File: rtl/vend_timer_pkg.sv
// Shared types and constants for the vending session timer and the vending FSM.
// Holds the session state encoding, default timing constants and a BCD helper.
package vend_timer_pkg;

    localparam int unsigned TIMEOUT_S_DEFAULT = 30;
    localparam int unsigned WARN_S_DEFAULT    = 5;

    typedef logic [1:0] vst_state_t;

    localparam vst_state_t ST_IDLE    = 2'd0;
    localparam vst_state_t ST_RUN     = 2'd1;
    localparam vst_state_t ST_EXPIRED = 2'd2;

    // Two-digit BCD; callers guarantee val <= 99.
    function automatic logic [7:0] to_bcd8(input int unsigned val);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'((val / 10) % 10);
        ones = 4'(val % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Two-flop level sampler with a one-cycle rising-edge pulse.
// RESET_VAL sets both flops at reset, so a level already at that value gives no pulse.
module rise_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic level_i,
    output logic rise_o
);

    logic s0_q;
    logic s1_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s0_q <= RESET_VAL;
            s1_q <= RESET_VAL;
        end else begin
            s0_q <= level_i;
            s1_q <= s0_q;
        end
    end

    assign rise_o = s0_q & ~s1_q;

endmodule

// File: rtl/vend_session_timer.sv
// Customer-session countdown timer driven by 1 s ticks derived from the divider's clk1hz.
// Define VST_BCD_OUT_EN to add the registered secs_bcd_o output.
module vend_session_timer
    import vend_timer_pkg::*;
#(
    parameter int unsigned TIMEOUT_S = TIMEOUT_S_DEFAULT,
    parameter int unsigned WARN_S    = WARN_S_DEFAULT,
    parameter int unsigned CNT_W     = 6
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             clk1hz_i,
    input  logic             start_i,
    input  logic             kick_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             warn_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] secs_left_o
`ifdef VST_BCD_OUT_EN
    ,
    output logic [7:0]       secs_bcd_o
`endif
);

    localparam int unsigned      CNT_MAX    = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_S);
    localparam logic [CNT_W-1:0] WARN_LV    = CNT_W'(WARN_S);
    localparam logic             WARN_EN    = (WARN_S != 0);

    generate
        if (TIMEOUT_S == 0 || TIMEOUT_S > CNT_MAX || WARN_S >= TIMEOUT_S) begin : g_bad_param
            $error("vend_session_timer: illegal TIMEOUT_S/WARN_S/CNT_W combination");
        end
    endgenerate

    logic             tick;
    vst_state_t       state_q;
    vst_state_t       state_d;
    logic [CNT_W-1:0] secs_q;
    logic [CNT_W-1:0] secs_d;

    rise_edge_detect #(
        .RESET_VAL (1'b1)
    ) u_tick (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .level_i  (clk1hz_i),
        .rise_o   (tick)
    );

    always_comb begin
        state_d = state_q;
        secs_d  = secs_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    secs_d  = TIMEOUT_LD;
                end
            end
            ST_RUN: begin
                if (cancel_i) begin
                    state_d = ST_IDLE;
                    secs_d  = '0;
                end else if (kick_i || start_i) begin
                    // Reload wins over a coincident tick, which is simply dropped.
                    secs_d = TIMEOUT_LD;
                end else if (tick) begin
                    if (secs_q == CNT_W'(1)) begin
                        state_d = ST_EXPIRED;
                        secs_d  = '0;
                    end else if (secs_q >= CNT_W'(2)) begin
                        secs_d = secs_q - CNT_W'(1);
                    end
                end
            end
            ST_EXPIRED: begin
                state_d = ST_IDLE;
                secs_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                secs_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            secs_q  <= '0;
        end else begin
            state_q <= state_d;
            secs_q  <= secs_d;
        end
    end

    assign busy_o      = (state_q == ST_RUN);
    assign warn_o      = busy_o && WARN_EN && (secs_q <= WARN_LV);
    assign timeout_o   = (state_q == ST_EXPIRED);
    assign secs_left_o = secs_q;

`ifdef VST_BCD_OUT_EN
    generate
        if (TIMEOUT_S > 99) begin : g_bad_bcd
            $error("vend_session_timer: TIMEOUT_S must be <= 99 with BCD output");
        end
    endgenerate

    logic [7:0] secs_bcd_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            secs_bcd_q <= 8'h00;
        end else begin
            secs_bcd_q <= to_bcd8(32'(secs_q));
        end
    end

    assign secs_bcd_o = secs_bcd_q;
`endif

endmodule
